// File: rtl/seg7_hex_scroller.sv
// Buffered 32-bit word display for a single seven-segment digit: each word is shown as
// eight hex digits, MSB nibble first, with a blank gap after every digit.
module seg7_hex_scroller #(
  parameter int unsigned DWELL_CYCLES = 1024,
  parameter int unsigned BLANK_CYCLES = 256,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic [6:0]  segments,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned MaxCycles = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW        = $clog2(MaxCycles) + 1;

  localparam logic [CW-1:0] DwellLoad = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BlankLoad = CW'(BLANK_CYCLES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StShow = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        full_q, full_d;
  logic        empty;
  logic        push;
  logic        pop;
  logic [31:0] head;

  assign empty    = (wptr_q == rptr_q);
  assign wr_ready = ~full_q;
  assign push     = wr_valid & ~full_q;
  assign head     = mem_q[rptr_q[AW-1:0]];

  // Full is registered from the next pointers so it is exact on every cycle.
  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
    full_d = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      full_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Hex font, bit0 = segment a ... bit6 = segment g
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // Display sequencer
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic [6:0]    segments_q, segments_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          word_d  = head;
          idx_d   = 3'd7;
          cnt_d   = DwellLoad;
          state_d = StShow;
        end
      end
      StShow: begin
        if (cnt_q == '0) begin
          cnt_d   = BlankLoad;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q != 3'd0) begin
          // The displayed nibble always sits in the top of the shift register.
          idx_d   = idx_q - 3'd1;
          word_d  = {word_q[27:0], 4'h0};
          cnt_d   = DwellLoad;
          state_d = StShow;
        end else if (!empty) begin
          pop     = 1'b1;
          word_d  = head;
          idx_d   = 3'd7;
          cnt_d   = DwellLoad;
          state_d = StShow;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    segments_d = (state_d == StShow) ? font(word_d[31:28]) : 7'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      word_q     <= '0;
      segments_q <= 7'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      segments_q <= segments_d;
    end
  end

  assign segments = segments_q;
  assign busy     = (state_q != StIdle) || !empty;

endmodule
